// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter
//   Shares one Gowin single-port BSRAM between NUM_CLIENTS engines.
//   MODE 0: legacy select-driven mux (owner = registered select).
//   MODE 1: round-robin request/grant with ownership lock and a read drain
//           on every ownership change.
//   Every read is tagged with its issuing owner so the read-valid strobe is
//   routed back to that client even if ownership moves on meanwhile.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   select              owner choice (MODE 0 only)
//   req                 per-client level request (MODE 1 only)
//   gnt                 one-hot registered grant
//   c_ce/c_oce/c_wre    per-client BSRAM controls
//   c_ad, c_din         flattened per-client address / write data
//   c_rvalid            per-client one-cycle read-data-valid strobe
//   c_dout              broadcast of ram_dout
//   ram_*               BSRAM port
//   busy                owner holds the port or a drain is in progress
module sp_ram_arbiter #(
    parameter int unsigned NUM_CLIENTS  = 3,
    parameter int unsigned SEL_WIDTH    = 2,
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MODE         = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SEL_WIDTH-1:0]             select,
    input  logic [NUM_CLIENTS-1:0]           req,
    output logic [NUM_CLIENTS-1:0]           gnt,
    input  logic [NUM_CLIENTS-1:0]           c_ce,
    input  logic [NUM_CLIENTS-1:0]           c_oce,
    input  logic [NUM_CLIENTS-1:0]           c_wre,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_ad,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_din,
    output logic [NUM_CLIENTS-1:0]           c_rvalid,
    output logic [DATA_WIDTH-1:0]            c_dout,
    output logic                             ram_ce,
    output logic                             ram_oce,
    output logic                             ram_wre,
    output logic [ADDR_WIDTH-1:0]            ram_ad,
    output logic [DATA_WIDTH-1:0]            ram_din,
    input  logic [DATA_WIDTH-1:0]            ram_dout,
    output logic                             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_DRAIN
    } state_t;

    localparam logic [SEL_WIDTH-1:0] LAST_CLIENT = SEL_WIDTH'(NUM_CLIENTS - 1);

    state_t                 r_state, w_state_nxt;
    logic [SEL_WIDTH-1:0]   r_owner, w_owner_nxt;
    logic [SEL_WIDTH-1:0]   r_rr, w_rr_nxt;
    logic [NUM_CLIENTS-1:0] r_gnt, w_gnt_nxt;
    logic [2:0]             r_drain_cnt, w_drain_cnt_nxt;

    logic [SEL_WIDTH-1:0]   w_sel_clamped;
    logic [SEL_WIDTH-1:0]   w_rr_pick;
    logic                   w_rr_found;
    logic [SEL_WIDTH:0]     w_idx;
    logic                   w_active;
    logic                   w_push;

    logic [READ_LATENCY-1:0] r_tag_v;
    logic [SEL_WIDTH-1:0]    r_tag_o [READ_LATENCY];

    function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
        logic [NUM_CLIENTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Out-of-range select falls back to the last client.
    always_comb begin
        w_sel_clamped = select;
        if (32'(select) >= 32'(NUM_CLIENTS)) begin
            w_sel_clamped = LAST_CLIENT;
        end
    end

    // First requester at or above the rr pointer, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pick  = '0;
        w_idx      = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            w_idx = (SEL_WIDTH+1)'(r_rr) + (SEL_WIDTH+1)'(i);
            if (32'(w_idx) >= 32'(NUM_CLIENTS)) begin
                w_idx = w_idx - (SEL_WIDTH+1)'(NUM_CLIENTS);
            end
            if (!w_rr_found && req[w_idx[SEL_WIDTH-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = w_idx[SEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_nxt        = r_rr;
        w_gnt_nxt       = r_gnt;
        w_drain_cnt_nxt = r_drain_cnt;
        if (MODE == 0) begin
            w_state_nxt = S_IDLE;
            w_owner_nxt = w_sel_clamped;
            w_gnt_nxt   = onehot(w_sel_clamped);
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_rr_found) begin
                        w_owner_nxt = w_rr_pick;
                        w_gnt_nxt   = onehot(w_rr_pick);
                        w_state_nxt = S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!req[r_owner]) begin
                        w_gnt_nxt       = '0;
                        w_rr_nxt        = (r_owner == LAST_CLIENT) ? '0 : r_owner + SEL_WIDTH'(1);
                        w_drain_cnt_nxt = 3'(READ_LATENCY);
                        w_state_nxt     = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    w_drain_cnt_nxt = r_drain_cnt - 3'd1;
                    if (r_drain_cnt == 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr        <= '0;
            r_gnt       <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr        <= w_rr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // RAM-side mux. Gated by rst so the port is quiet while reset is held.
    // oce stays high through DRAIN so reads already issued reach dout.
    always_comb begin
        w_active = !rst && ((MODE == 0) || (r_state == S_GRANT));
        ram_ce   = 1'b0;
        ram_wre  = 1'b0;
        ram_oce  = 1'b0;
        ram_ad   = '0;
        ram_din  = '0;
        if (w_active) begin
            ram_ce  = c_ce[r_owner];
            ram_wre = c_wre[r_owner];
            ram_oce = c_oce[r_owner];
            ram_ad  = c_ad[r_owner*ADDR_WIDTH +: ADDR_WIDTH];
            ram_din = c_din[r_owner*DATA_WIDTH +: DATA_WIDTH];
        end else if (!rst && (MODE != 0) && (r_state == S_DRAIN)) begin
            ram_oce = 1'b1;
        end
    end

    assign w_push = ram_ce & ~ram_wre;

    // Read-tag shift register: one stage per cycle of RAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                r_tag_o[i] <= '0;
            end
        end else begin
            r_tag_v[0] <= w_push;
            r_tag_o[0] <= r_owner;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_o[i] <= r_tag_o[i-1];
            end
        end
    end

    assign c_rvalid = r_tag_v[READ_LATENCY-1] ? onehot(r_tag_o[READ_LATENCY-1]) : '0;
    assign gnt      = r_gnt;
    assign c_dout   = ram_dout;
    assign busy     = (MODE != 0) && (r_state != S_IDLE);

endmodule

// File: tb/tb_sp_ram_arbiter.sv
module tb_sp_ram_arbiter;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- MODE 1 instance ----------------
    logic [SW-1:0]   sel1 = '0;
    logic [N-1:0]    req1, gnt1, ce1, oce1, wre1, rvalid1;
    logic [N*AW-1:0] ad1;
    logic [N*DW-1:0] din1;
    logic [DW-1:0]   dout1, rdout1, rdin1;
    logic            rce1, roce1, rwre1, busy1;
    logic [AW-1:0]   rad1;

    sp_ram_arbiter #(.NUM_CLIENTS(N), .SEL_WIDTH(SW), .ADDR_WIDTH(AW),
                     .DATA_WIDTH(DW), .READ_LATENCY(2), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .select(sel1), .req(req1), .gnt(gnt1),
        .c_ce(ce1), .c_oce(oce1), .c_wre(wre1), .c_ad(ad1), .c_din(din1),
        .c_rvalid(rvalid1), .c_dout(dout1),
        .ram_ce(rce1), .ram_oce(roce1), .ram_wre(rwre1), .ram_ad(rad1),
        .ram_din(rdin1), .ram_dout(rdout1), .busy(busy1)
    );

    // ---------------- MODE 0 instance ----------------
    logic [SW-1:0]   sel0;
    logic [N-1:0]    req0 = '0;
    logic [N-1:0]    gnt0, ce0, oce0, wre0, rvalid0;
    logic [N*AW-1:0] ad0;
    logic [N*DW-1:0] din0;
    logic [DW-1:0]   dout0, rdout0, rdin0;
    logic            rce0, roce0, rwre0, busy0;
    logic [AW-1:0]   rad0;

    sp_ram_arbiter #(.NUM_CLIENTS(N), .SEL_WIDTH(SW), .ADDR_WIDTH(AW),
                     .DATA_WIDTH(DW), .READ_LATENCY(2), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .select(sel0), .req(req0), .gnt(gnt0),
        .c_ce(ce0), .c_oce(oce0), .c_wre(wre0), .c_ad(ad0), .c_din(din0),
        .c_rvalid(rvalid0), .c_dout(dout0),
        .ram_ce(rce0), .ram_oce(roce0), .ram_wre(rwre0), .ram_ad(rad0),
        .ram_din(rdin0), .ram_dout(rdout0), .busy(busy0)
    );

    // ---------------- BSRAM models (read latency 2 with oce stage) ----------------
    logic [DW-1:0] mem1 [0:2047];
    logic [DW-1:0] mem0 [0:2047];
    logic [DW-1:0] q1, o1, q0, o0;
    logic          pl_en = 1'b0;
    int            pl_which;
    logic [AW-1:0] pl_a;
    logic [DW-1:0] pl_d;

    always @(posedge clk) begin
        if (pl_en && pl_which == 1) mem1[pl_a] <= pl_d;
        else if (rce1 && rwre1)     mem1[rad1] <= rdin1;
        if (rce1 && !rwre1) q1 <= mem1[rad1];
        if (roce1) o1 <= q1;
    end
    assign rdout1 = o1;

    always @(posedge clk) begin
        if (pl_en && pl_which == 0) mem0[pl_a] <= pl_d;
        else if (rce0 && rwre0)     mem0[rad0] <= rdin0;
        if (rce0 && !rwre0) q0 <= mem0[rad0];
        if (roce0) o0 <= q0;
    end
    assign rdout0 = o0;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic preload(input int which, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en    = 1'b1;
        pl_which = which;
        pl_a     = a;
        pl_d     = d;
        step(1);
        pl_en    = 1'b0;
    endtask

    logic [N-1:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int           rr_own [4] = '{0, 1, 2, 0};
    int           t_drop;
    int           waited;
    int           o;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with busy client inputs on both instances.
        req1 = '1; ce1 = '1; wre1 = '1; oce1 = '1;
        ad1  = {11'h7FF, 11'h555, 11'h2AA};
        din1 = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        sel0 = 2'd1; ce0 = '1; wre0 = '1; oce0 = '1;
        ad0  = {11'h102, 11'h101, 11'h100};
        din0 = {32'hA2, 32'hA1, 32'hA0};
        step(1);
        #1;
        check("rst_gnt1",   gnt1, 3'b000);
        check("rst_rv1",    rvalid1, 3'b000);
        check("rst_busy1",  busy1, 1'b0);
        check("rst_ce1",    {rce1, roce1, rwre1}, 3'b000);
        check("rst_ad1",    rad1, 11'h000);
        check("rst_din1",   rdin1, 32'h0);
        check("rst_gnt0",   gnt0, 3'b000);
        check("rst_ce0",    {rce0, roce0, rwre0}, 3'b000);
        check("rst_ad0",    rad0, 11'h000);
        check("rst_din0",   rdin0, 32'h0);

        preload(1, 11'h123, 32'hDEAD_BEEF);
        preload(1, 11'h007, 32'hCAFE_0007);
        preload(1, 11'h009, 32'h0000_0099);
        preload(0, 11'h100, 32'h0BAD_F00D);

        req1 = '0; ce1 = '0; wre1 = '0;
        sel0 = 2'd0; ce0 = '0; wre0 = '0;
        rst  = 1'b0;
        step(1);

        // ---------- basic read, client 1 ----------
        req1 = 3'b010;
        #1 check("req_lat0", gnt1, 3'b000);
        step(1);
        check("basic_gnt",  gnt1, 3'b010);
        check("basic_busy", busy1, 1'b1);
        ce1 = 3'b010;
        ad1[1*AW +: AW] = 11'h123;
        #1;
        check("basic_rce", {rce1, rwre1}, 2'b10);
        check("basic_rad", rad1, 11'h123);
        step(1);
        ce1 = '0;
        check("basic_rv_early", rvalid1, 3'b000);
        step(1);
        check("basic_rv",   rvalid1, 3'b010);
        check("basic_dout", dout1, 32'hDEAD_BEEF);
        step(1);
        check("basic_rv_once", rvalid1, 3'b000);
        req1 = '0;
        step(1);
        check("drain_gnt",  gnt1, 3'b000);
        check("drain_busy", busy1, 1'b1);
        check("drain_oce",  {rce1, roce1}, 2'b01);
        step(2);
        check("idle_busy", busy1, 1'b0);

        // ---------- reset mid-read ----------
        req1 = 3'b001;
        step(1);
        check("mid_gnt", gnt1, 3'b001);
        ce1 = 3'b001;
        ad1[0 +: AW] = 11'd5;
        step(1);
        ad1[0 +: AW] = 11'd6;
        #3 rst = 1'b1;
        #1;
        check("mid_rst_gnt",  gnt1, 3'b000);
        check("mid_rst_rv",   rvalid1, 3'b000);
        check("mid_rst_ram",  {rce1, roce1, rwre1}, 3'b000);
        check("mid_rst_ad",   rad1, 11'h000);
        check("mid_rst_busy", busy1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("mid_rst_hold_rv", rvalid1, 3'b000);
            check("mid_rst_hold_ce", rce1, 1'b0);
        end
        ce1 = '0; req1 = '0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("mid_post_rv",  rvalid1, 3'b000);
            check("mid_post_gnt", gnt1, 3'b000);
        end

        // ---------- round-robin with all clients requesting ----------
        req1 = 3'b111;
        step(1);
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (gnt1 == 3'b000 && waited < 10) begin
                step(1);
                waited++;
            end
            check("rr_gnt", gnt1, rr_exp[k]);
            if (k > 0) check("rr_gap", cyc - t_drop, 4);
            o = rr_own[k];
            for (int a = 0; a < 4; a++) begin
                ce1  = rr_exp[k];
                wre1 = rr_exp[k];
                ad1[o*AW +: AW]  = 11'(32'h200 + k*4 + a);
                din1[o*DW +: DW] = 32'(k*16 + a);
                step(1);
            end
            ce1 = '0; wre1 = '0;
            req1 = (k == 3) ? 3'b000 : (3'b111 & ~rr_exp[k]);
            t_drop = cyc;
            step(1);
            if (k < 3) req1 = 3'b111;
        end
        step(2);
        check("rr_end_busy", busy1, 1'b0);

        // ---------- drain: client 2 reads and drops req, client 0 waits ----------
        req1 = 3'b100;
        step(1);
        check("drn_gnt2", gnt1, 3'b100);
        ce1 = 3'b100;
        ad1[2*AW +: AW] = 11'd7;
        req1 = 3'b001;
        step(1);
        ce1 = '0;
        check("drn_gnt_a", gnt1, 3'b000);
        check("drn_rv_a",  rvalid1, 3'b000);
        step(1);
        check("drn_rv",    rvalid1, 3'b100);
        check("drn_dout",  dout1, 32'hCAFE_0007);
        check("drn_gnt_b", gnt1, 3'b000);
        step(1);
        check("drn_gnt_c", gnt1, 3'b000);
        step(1);
        check("drn_gnt0",  gnt1, 3'b001);

        // ---------- isolation: client 1 writes while client 0 owns ----------
        ce1  = 3'b010;
        wre1 = 3'b010;
        ad1[1*AW +: AW]  = 11'd9;
        din1[1*DW +: DW] = 32'h0000_FFFF;
        #1 check("iso_ram_ctl", {rce1, rwre1}, 2'b00);
        step(2);
        ce1 = 3'b001; wre1 = '0;
        ad1[0 +: AW] = 11'd9;
        #1;
        check("iso_rd_ce", rce1, 1'b1);
        check("iso_rd_ad", rad1, 11'd9);
        step(1);
        ce1 = '0;
        step(1);
        check("iso_rv",   rvalid1, 3'b001);
        check("iso_dout", dout1, 32'h0000_0099);
        req1 = '0;
        step(3);

        // ---------- MODE 0 legacy select ----------
        check("m0_gnt0", gnt0, 3'b001);
        check("m0_ad0",  rad0, 11'h100);
        check("m0_busy", busy0, 1'b0);
        ce0  = 3'b001;
        sel0 = 2'd1;
        #1 check("m0_rd_ce", {rce0, rwre0}, 2'b10);
        step(1);
        ce0 = '0;
        check("m0_gnt1", gnt0, 3'b010);
        check("m0_ad1",  rad0, 11'h101);
        check("m0_rv_early", rvalid0, 3'b000);
        sel0 = 2'd3;
        step(1);
        check("m0_rv",   rvalid0, 3'b001);
        check("m0_dout", dout0, 32'h0BAD_F00D);
        check("m0_gnt2", gnt0, 3'b100);
        check("m0_ad2",  rad0, 11'h102);
        ce0  = 3'b101;
        wre0 = 3'b100;
        #1;
        check("m0_wr_ctl", {rce0, rwre0}, 2'b11);
        check("m0_wr_din", rdin0, 32'hA2);
        step(1);
        ce0 = '0; wre0 = '0;
        check("m0_no_rv_wr", rvalid0, 3'b000);
        step(2);
        check("m0_no_rv_late", rvalid0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
